// File: rtl/cpu_mem_pkg.sv
// Shared CPU-side memory definitions: response ownership and default bus widths.
package cpu_mem_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned SRAM_RD_LAT = 1;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } req_owner_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Fetch/data request handshakes plus the unified SRAM port, bundled as one bus.
interface sram_port_arbiter_if
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  localparam int unsigned STRB_W = DATA_W / 8;

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [STRB_W-1:0] data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic              sram_en;
  logic [STRB_W-1:0] sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  // Arbiter side.
  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  sram_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata
  );

  // Core / memory side.
  modport master (
    output inst_req, inst_addr,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output sram_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata
  );

endinterface

// File: rtl/arb_grant_sel.sv
// Combinational grant decision: data wins unless fetch has waited out the streak limit.
module arb_grant_sel #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic       inst_req,
  input  logic       data_req,
  input  logic [3:0] streak,
  output logic       grant_inst,
  output logic       grant_data
);

  logic starved;

  assign starved = (streak >= 4'(MAX_DATA_STREAK));

  // Data has priority; a starved, waiting fetch takes the slot instead.
  always_comb begin
    grant_data = data_req && !(inst_req && starved);
    grant_inst = inst_req && !grant_data;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data access.
module sram_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W          = ADDR_W_DEF,
  parameter int unsigned DATA_W          = DATA_W_DEF,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input logic               clk,
  input logic               reset,
  sram_port_arbiter_if.slave bus
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [3:0]        streak;
  logic              resp_valid;
  req_owner_e        resp_owner;
  logic              inst_req_g;
  logic              data_req_g;
  logic              grant_inst;
  logic              grant_data;
  logic [ADDR_W-1:0] mux_addr;
  logic [STRB_W-1:0] mux_we;

  // No grants can be issued while reset is held.
  assign inst_req_g = bus.inst_req & ~reset;
  assign data_req_g = bus.data_req & ~reset;

  arb_grant_sel #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_grant_sel (
    .inst_req  (inst_req_g),
    .data_req  (data_req_g),
    .streak    (streak),
    .grant_inst(grant_inst),
    .grant_data(grant_data)
  );

  // SRAM port steering: address follows the grant, idle cycles park on the data side.
  always_comb begin
    mux_addr = grant_inst ? bus.inst_addr : bus.data_addr;
    mux_we   = (grant_data && bus.data_wr) ? bus.data_wstrb : '0;
  end

  assign bus.sram_en      = grant_inst | grant_data;
  assign bus.sram_we      = mux_we;
  assign bus.sram_addr    = mux_addr;
  assign bus.sram_wdata   = bus.data_wdata;

  assign bus.inst_addr_ok = grant_inst;
  assign bus.data_addr_ok = grant_data;

  assign bus.inst_data_ok = resp_valid && (resp_owner == OWNER_INST);
  assign bus.data_data_ok = resp_valid && (resp_owner == OWNER_DATA);
  assign bus.inst_rdata   = bus.sram_rdata;
  assign bus.data_rdata   = bus.sram_rdata;

  // Response tracking and data-streak counting, one response in flight per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak     <= '0;
      resp_valid <= 1'b0;
      resp_owner <= OWNER_INST;
    end else begin
      resp_valid <= grant_inst | grant_data;
      if (grant_inst || grant_data) begin
        resp_owner <= grant_data ? OWNER_DATA : OWNER_INST;
      end
      if (grant_data && bus.inst_req) begin
        if (streak < 4'(MAX_DATA_STREAK)) begin
          streak <= streak + 4'd1;
        end
      end else begin
        streak <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural SRAM, reference model, directed and random traffic.
module tb_sram_port_arbiter;

  localparam int unsigned AW         = 32;
  localparam int unsigned DW         = 32;
  localparam int unsigned MAX_STREAK = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_port_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .MAX_DATA_STREAK(MAX_STREAK)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // 1 KiB word memory; higher address bits alias.
  function automatic int unsigned widx(input logic [31:0] a);
    return {24'd0, a[9:2]};
  endfunction

  function automatic logic [31:0] init_word(input int unsigned i);
    return (i * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Behavioural SRAM (the DUT's memory, not the reference).
  logic [31:0] sram_mem [256];
  bit          sram_vld [256];

  function automatic logic [31:0] sram_rd(input logic [31:0] a);
    return sram_vld[widx(a)] ? sram_mem[widx(a)] : init_word(widx(a));
  endfunction

  // One-cycle-latency synchronous SRAM.
  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_we != 4'h0) begin
        sram_mem[widx(bus.sram_addr)] <= merge(sram_rd(bus.sram_addr), bus.sram_we, bus.sram_wdata);
        sram_vld[widx(bus.sram_addr)] <= 1'b1;
      end else begin
        bus.sram_rdata <= sram_rd(bus.sram_addr);
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [256];
  bit          ref_vld [256];
  int unsigned m_streak    = 0;
  bit          m_pend      = 1'b0;
  bit          m_pend_inst = 1'b0;
  bit          m_pend_wr   = 1'b0;
  logic [31:0] m_pend_data = '0;

  bit          obs_gi, obs_gd, obs_iok, obs_dok;
  logic [31:0] obs_drdata;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_vld[widx(a)] ? ref_mem[widx(a)] : init_word(widx(a));
  endfunction

  // One clock cycle: entered at posedge+1 with inputs set, leaves at the next posedge+1.
  task automatic cycle();
    bit g_i, g_d;
    #2;
    g_d = bus.data_req && (!bus.inst_req || m_streak < MAX_STREAK);
    g_i = bus.inst_req && !g_d;

    obs_gi     = bus.inst_addr_ok;
    obs_gd     = bus.data_addr_ok;
    obs_iok    = bus.inst_data_ok;
    obs_dok    = bus.data_data_ok;
    obs_drdata = bus.data_rdata;

    check_eq("inst_addr_ok", bus.inst_addr_ok, g_i);
    check_eq("data_addr_ok", bus.data_addr_ok, g_d);
    check_eq("sram_en", bus.sram_en, g_i | g_d);
    check_eq("sram_we", bus.sram_we, (g_d && bus.data_wr) ? bus.data_wstrb : 4'h0);
    if (g_i) check_eq("sram_addr_i", bus.sram_addr, bus.inst_addr);
    if (g_d) check_eq("sram_addr_d", bus.sram_addr, bus.data_addr);
    if (g_d && bus.data_wr) check_eq("sram_wdata", bus.sram_wdata, bus.data_wdata);

    check_eq("inst_data_ok", bus.inst_data_ok, m_pend && m_pend_inst);
    check_eq("data_data_ok", bus.data_data_ok, m_pend && !m_pend_inst);
    check_eq("one_resp", bus.inst_data_ok & bus.data_data_ok, 1'b0);
    if (m_pend && m_pend_inst) check_eq("inst_rdata", bus.inst_rdata, m_pend_data);
    if (m_pend && !m_pend_inst && !m_pend_wr) check_eq("data_rdata", bus.data_rdata, m_pend_data);

    m_pend      = g_i | g_d;
    m_pend_inst = g_i;
    m_pend_wr   = g_d && bus.data_wr;
    if (g_i) m_pend_data = ref_rd(bus.inst_addr);
    else if (g_d && !bus.data_wr) m_pend_data = ref_rd(bus.data_addr);
    if (g_d && bus.data_wr) begin
      ref_mem[widx(bus.data_addr)] = merge(ref_rd(bus.data_addr), bus.data_wstrb, bus.data_wdata);
      ref_vld[widx(bus.data_addr)] = 1'b1;
    end
    if (g_d && bus.inst_req) m_streak = (m_streak < MAX_STREAK) ? m_streak + 1 : m_streak;
    else m_streak = 0;

    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    #2;
    check_eq({tag, "_inst_addr_ok"}, bus.inst_addr_ok, 1'b0);
    check_eq({tag, "_data_addr_ok"}, bus.data_addr_ok, 1'b0);
    check_eq({tag, "_inst_data_ok"}, bus.inst_data_ok, 1'b0);
    check_eq({tag, "_data_data_ok"}, bus.data_data_ok, 1'b0);
    check_eq({tag, "_sram_en"}, bus.sram_en, 1'b0);
    check_eq({tag, "_sram_we"}, bus.sram_we, 4'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_streak = 0;
    m_pend   = 1'b0;
  endtask

  initial begin
    bus.inst_req   = 1'b0;
    bus.inst_addr  = '0;
    bus.data_req   = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_wstrb = '0;
    bus.data_addr  = '0;
    bus.data_wdata = '0;
    for (int i = 0; i < 256; i++) ref_vld[i] = 1'b0;

    // Reset state, with requests asserted to show grants are suppressed.
    repeat (2) @(posedge clk);
    #1;
    bus.inst_req = 1'b1;
    bus.data_req = 1'b1;
    check_reset_outputs("rst");
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;
    reset = 1'b0;
    model_reset();

    // Idle.
    repeat (10) cycle();

    // Fetch only.
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1C00_0000;
    repeat (3) cycle();
    bus.inst_req = 1'b0;
    cycle();

    // Data write over prior contents, then read back.
    bus.data_req   = 1'b1;
    bus.data_wr    = 1'b1;
    bus.data_addr  = 32'h0000_0100;
    bus.data_wstrb = 4'hF;
    bus.data_wdata = 32'h1122_3344;
    cycle();
    bus.data_wstrb = 4'b0011;
    bus.data_wdata = 32'hAABB_CCDD;
    cycle();
    check_eq("wr_ack", obs_dok, 1'b1);
    bus.data_wr = 1'b0;
    cycle();
    check_eq("wr2_ack", obs_dok, 1'b1);
    bus.data_req = 1'b0;
    cycle();
    check_eq("rd_ok", obs_dok, 1'b1);
    check_eq("rd_value", obs_drdata, 32'h1122_CCDD);

    // Interleave: data at t, fetch at t+1.
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h0000_0104;
    cycle();
    bus.data_req  = 1'b0;
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1C00_0010;
    cycle();
    check_eq("ilv_t1_dok", obs_dok, 1'b1);
    check_eq("ilv_t1_iok", obs_iok, 1'b0);
    bus.inst_req = 1'b0;
    cycle();
    check_eq("ilv_t2_iok", obs_iok, 1'b1);
    check_eq("ilv_t2_dok", obs_dok, 1'b0);

    // Contention: expect D,D,D,D,I repeating.
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1C00_0040;
    bus.data_req  = 1'b1;
    bus.data_wr   = 1'b0;
    for (int k = 0; k < 15; k++) begin
      cycle();
      check_eq("contend_grant_d", obs_gd, (k % 5) != 4);
      check_eq("contend_grant_i", obs_gi, (k % 5) == 4);
      if (obs_gd) bus.data_addr = 32'($urandom_range(0, 255)) * 4;
    end
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;
    cycle();

    // Reset one cycle after a data read grant: response must be dropped.
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h0000_0108;
    cycle();
    bus.data_req  = 1'b0;
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1C00_0020;
    reset = 1'b1;
    check_reset_outputs("midrst_a");
    check_reset_outputs("midrst_b");
    reset = 1'b0;
    model_reset();
    cycle();
    check_eq("post_rst_grant", obs_gi, 1'b1);
    bus.inst_req = 1'b0;
    cycle();
    check_eq("post_rst_iok", obs_iok, 1'b1);

    // Random traffic honouring the hold-until-accepted rule.
    for (int n = 0; n < 400; n++) begin
      if (!bus.inst_req || obs_gi) begin
        bus.inst_req  = ($urandom_range(0, 99) < 60);
        bus.inst_addr = 32'h1C00_0000 + 32'($urandom_range(0, 255)) * 4;
      end
      if (!bus.data_req || obs_gd) begin
        bus.data_req   = ($urandom_range(0, 99) < 70);
        bus.data_wr    = 1'($urandom_range(0, 1));
        bus.data_wstrb = 4'($urandom_range(1, 15));
        bus.data_addr  = 32'($urandom_range(0, 255)) * 4;
        bus.data_wdata = $urandom;
      end
      obs_gi = 1'b0;
      obs_gd = 1'b0;
      cycle();
    end
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port synchronous SRAM between the CPU's instruction-fetch and data-access requesters. Both sides use a req/addr_ok/data_ok handshake with one cycle of latency. The block sits between the CPU core and the unified memory. It grants one request per cycle and prioritises data over fetch, with a bounded-starvation guard for fetch. It then returns read data or a write acknowledge to the requester that owns each response.

## Interface
Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits; byte strobes are DATA_W/8 bits wide.
- MAX_DATA_STREAK, 4, maximum consecutive data grants while fetch is waiting; range 1..15.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_req  in  1  fetch request valid.
- inst_addr  in  ADDR_W  fetch address.
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch read data valid this cycle.
- inst_rdata  out  DATA_W  fetch read data.
- data_req  in  1  data request valid.
- data_wr  in  1  1 = write, 0 = read.
- data_wstrb  in  DATA_W/8  byte-write enables; ignored on reads.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  write data.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  read data valid, or write complete, this cycle.
- data_rdata  out  DATA_W  data read data.
- sram_en  out  1  SRAM access enable.
- sram_we  out  DATA_W/8  SRAM byte write enables.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data, valid one cycle after an enabled read.

## Operation
- Grant logic is combinational each cycle:
  - Only one requester asserts req: it is granted.
  - Both assert req: data is granted, unless streak == MAX_DATA_STREAK; then fetch is granted.
- Granted side sees addr_ok=1 in that cycle. The SRAM is driven the same cycle:
  - sram_en = 1.
  - sram_addr = the granted address.
  - sram_we = data_wstrb when a data write is granted, otherwise 0.
  - sram_wdata = data_wdata.
- No grant: sram_en = 0 and sram_we = 0. sram_addr and sram_wdata are don't-care but stable, driven from the data side.
- Streak counter, 4 bits:
  - Data granted while inst_req = 1: increment.
  - Fetch granted, or inst_req = 0: clear to 0.
  - Saturates at MAX_DATA_STREAK.
- Response tracker registers resp_valid and resp_owner (INST or DATA) at each grant.
- In the next cycle, exactly one of inst_data_ok or data_data_ok pulses, selected by resp_owner.
  - inst_rdata and data_rdata both pass sram_rdata through.
  - data_rdata is don't-care for a write response.
- Back-to-back grants are allowed every cycle; there is at most one response in flight per cycle.
- Requesters must hold req, addr, wr, wstrb and wdata stable until addr_ok. The block does not check this.
- Simultaneous events:
  - A new grant and the previous response in the same cycle are both legal and independent.
  - A fetch grant while a data response is returning is legal.

## Timing
- Request to addr_ok: 0 cycles (combinational).
- addr_ok to data_ok: exactly 1 cycle.
- Sustained throughput: 1 access per cycle.
- Reset (asynchronous assert, synchronous internal release):
  - resp_valid = 0, resp_owner = INST, streak = 0.
  - All *_data_ok = 0. addr_ok outputs are 0 while reset = 1.
  - sram_en = 0, sram_we = 0.
- Reset asserted mid-transaction: the pending response is dropped and no data_ok fires after release.
- First grant is possible in the first cycle with reset = 0.

## Structure
- Shared package cpu_mem_pkg:
  - enum req_owner_e {OWNER_INST, OWNER_DATA}.
  - SRAM_RD_LAT = 1.
  - Default ADDR_W and DATA_W constants, reused by the core and the AXI bridge later.
- Sub-module arb_grant_sel: purely combinational priority and starvation-guard decision. Inputs are inst_req, data_req and streak; outputs are grant_inst and grant_data.
- The top level holds the streak counter, response tracker and SRAM muxing.

## Test plan
- Fetch only: inst_req=1, inst_addr=0x1C000000 for 3 cycles. Required: inst_addr_ok each cycle; inst_data_ok on cycles 2..4 carrying the SRAM contents at 0x1C000000; sram_we=0.
- Data write then read: write addr 0x00000100, wstrb=4'b0011, wdata=0xAABBCCDD over prior 0x11223344; then read 0x100. Required: data_data_ok after each; read returns 0x1122CCDD.
- Contention, MAX_DATA_STREAK=4: both requesting continuously. Required grant pattern D,D,D,D,I repeating; streak returns to 0 after each I grant.
- Interleave: data grant at cycle t, fetch grant at t+1. Required: data_data_ok at t+1, inst_data_ok at t+2, never both in the same cycle.
- Reset mid-op: assert reset in the cycle after a data read grant. Required: data_data_ok stays 0; sram_en=0 while reset is high; after release, a fresh fetch request completes normally.
- Idle: no requests for 10 cycles. Required: sram_en=0 and all handshake outputs 0 throughout.
